rle_encoder_stream: RTL and testbench

Parametrised, single-clock run-length encoder with valid/ready handshakes on both sides. It is the successor of the escape-byte run-length encoder: symbol width, escape code, maximum run and minimum encoded run are all configurable, and it supports back-pressure and end-of-stream flush. It sits between a byte/symbol source and a serial or packet sink in the compression datapath.

---
 rtl/rle_encoder_stream.sv | 246 ++++++++++++++++++++++++
 tb/tb_rle_encoder_stream.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_encoder_stream.sv
// Run-length encoder with ESC/count/value tokens, valid/ready on both sides, end-of-stream flush.
// Latency: first encoded symbol is registered and appears the cycle after the accepting edge.
// Backpressure: in_ready is low while a token is being emitted; out_ready=0 stalls the FSM with output held.
//
// Ports:
//   fast_clk   - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready     - symbol input stream
//   out_data/out_valid/out_last/out_ready - encoded output stream
//   stat_in_cnt/stat_out_cnt - saturating handshake counters (only when RLE_STATS_EN is defined)
//
// Optional feature macro: RLE_STATS_EN
module rle_encoder_stream #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] ESC     = 8'h1B,
  parameter int                MAX_RUN = 255,
  parameter int                MIN_RUN = 3
) (
  input  logic              fast_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
`ifdef RLE_STATS_EN
  ,
  output logic [31:0]       stat_in_cnt,
  output logic [31:0]       stat_out_cnt
`endif
);

  localparam logic [DATA_W-1:0] L_MAX = DATA_W'(MAX_RUN);
  localparam logic [DATA_W-1:0] L_MIN = DATA_W'(MIN_RUN);
  localparam logic [DATA_W-1:0] L_ONE = DATA_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    EMIT_ESC,
    EMIT_CNT,
    EMIT_VAL,
    EMIT_LIT
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_pend;
  logic              r_pend_v;
  logic              r_pend_last;
  logic [DATA_W-1:0] r_rem;
  logic              r_flush;
  logic [DATA_W-1:0] r_out_dat;
  logic              r_out_vld;
  logic              r_out_last;

  state_t            w_state_nxt;
  logic [DATA_W-1:0] w_cur_nxt;
  logic [DATA_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] w_pend_nxt;
  logic              w_pend_v_nxt;
  logic              w_pend_last_nxt;
  logic [DATA_W-1:0] w_rem_nxt;
  logic              w_flush_nxt;
  logic              w_done;
  logic              w_in_acc;
  logic              w_out_acc;
  logic [DATA_W-1:0] w_out_dat_nxt;
  logic              w_out_vld_nxt;
  logic              w_out_last_nxt;

  // A run becomes a token if it is long enough or if the value is ESC itself
  // (a literal ESC would be ambiguous to the decoder).
  function automatic state_t f_start(input logic [DATA_W-1:0] v, input logic [DATA_W-1:0] c);
    f_start = ((c >= L_MIN) || (v == ESC)) ? EMIT_ESC : EMIT_LIT;
  endfunction

  assign in_ready  = (r_state == IDLE) || (r_state == ACCUM);
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = r_out_vld && out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur;
    w_cnt_nxt       = r_cnt;
    w_pend_nxt      = r_pend;
    w_pend_v_nxt    = r_pend_v;
    w_pend_last_nxt = r_pend_last;
    w_rem_nxt       = r_rem;
    w_flush_nxt     = r_flush;
    w_done          = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_in_acc) begin
          w_cur_nxt = in_data;
          w_cnt_nxt = L_ONE;
          w_rem_nxt = L_ONE;
          if (in_last) begin
            w_flush_nxt = 1'b1;
            w_state_nxt = f_start(in_data, L_ONE);
          end else begin
            w_state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (w_in_acc) begin
          if ((in_data == r_cur) && (r_cnt < L_MAX)) begin
            w_cnt_nxt = r_cnt + L_ONE;
            if (in_last) begin
              w_flush_nxt = 1'b1;
              w_rem_nxt   = r_cnt + L_ONE;
              w_state_nxt = f_start(r_cur, r_cnt + L_ONE);
            end
          end else begin
            // Breaking symbol (or MAX_RUN overflow): park it and emit the held run.
            w_pend_nxt      = in_data;
            w_pend_v_nxt    = 1'b1;
            w_pend_last_nxt = in_last;
            w_rem_nxt       = r_cnt;
            w_state_nxt     = f_start(r_cur, r_cnt);
          end
        end
      end
      EMIT_ESC: if (w_out_acc) w_state_nxt = EMIT_CNT;
      EMIT_CNT: if (w_out_acc) w_state_nxt = EMIT_VAL;
      EMIT_VAL: if (w_out_acc) w_done = 1'b1;
      EMIT_LIT: begin
        if (w_out_acc) begin
          if (r_rem > L_ONE) w_rem_nxt = r_rem - L_ONE;
          else               w_done    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_done) begin
      if (r_pend_v) begin
        w_cur_nxt    = r_pend;
        w_cnt_nxt    = L_ONE;
        w_rem_nxt    = L_ONE;
        w_pend_v_nxt = 1'b0;
        if (r_pend_last) begin
          // The parked symbol ended the stream: emit it on its own as the flush token.
          w_flush_nxt     = 1'b1;
          w_pend_last_nxt = 1'b0;
          w_state_nxt     = f_start(r_pend, L_ONE);
        end else begin
          w_flush_nxt = 1'b0;
          w_state_nxt = ACCUM;
        end
      end else begin
        w_flush_nxt = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    end
  end

  // Output register is loaded from the next-state view, so the symbol for a
  // state is on the port for the whole time the FSM sits in that state.
  always_comb begin
    w_out_vld_nxt  = 1'b0;
    w_out_dat_nxt  = '0;
    w_out_last_nxt = 1'b0;
    case (w_state_nxt)
      EMIT_ESC: begin
        w_out_vld_nxt = 1'b1;
        w_out_dat_nxt = ESC;
      end
      EMIT_CNT: begin
        w_out_vld_nxt = 1'b1;
        w_out_dat_nxt = w_cnt_nxt;
      end
      EMIT_VAL: begin
        w_out_vld_nxt  = 1'b1;
        w_out_dat_nxt  = w_cur_nxt;
        w_out_last_nxt = w_flush_nxt;
      end
      EMIT_LIT: begin
        w_out_vld_nxt  = 1'b1;
        w_out_dat_nxt  = w_cur_nxt;
        w_out_last_nxt = w_flush_nxt && (w_rem_nxt == L_ONE);
      end
      default: begin
        w_out_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_pend_v    <= 1'b0;
      r_pend_last <= 1'b0;
      r_rem       <= '0;
      r_flush     <= 1'b0;
      r_out_dat   <= '0;
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_last <= w_pend_last_nxt;
      r_rem       <= w_rem_nxt;
      r_flush     <= w_flush_nxt;
      r_out_dat   <= w_out_dat_nxt;
      r_out_vld   <= w_out_vld_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign out_data  = r_out_dat;
  assign out_valid = r_out_vld;
  assign out_last  = r_out_last;

`ifdef RLE_STATS_EN
  logic [31:0] r_stat_in;
  logic [31:0] r_stat_out;

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      r_stat_in  <= '0;
      r_stat_out <= '0;
    end else begin
      if (w_in_acc && (r_stat_in != '1))   r_stat_in  <= r_stat_in + 32'd1;
      if (w_out_acc && (r_stat_out != '1)) r_stat_out <= r_stat_out + 32'd1;
    end
  end

  assign stat_in_cnt  = r_stat_in;
  assign stat_out_cnt = r_stat_out;
`endif

endmodule

// File: tb/tb_rle_encoder_stream.sv
// Randomized scoreboard bench for rle_encoder_stream: a run-based reference
// model queues expected output symbols; a negedge monitor pops and compares.
// Also covers reset values, stall stability, in_ready during emission and mid-token reset.
module tb_rle_encoder_stream;

  localparam logic [7:0] ESC     = 8'h1B;
  localparam int         MAX_RUN = 255;
  localparam int         MIN_RUN = 3;

  logic       fast_clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
`ifdef RLE_STATS_EN
  logic [31:0] stat_in_cnt;
  logic [31:0] stat_out_cnt;
`endif

  rle_encoder_stream dut (
    .fast_clk (fast_clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready)
`ifdef RLE_STATS_EN
    ,
    .stat_in_cnt (stat_in_cnt),
    .stat_out_cnt(stat_out_cnt)
`endif
  );

  always #5 fast_clk = ~fast_clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];   // {last, data}
  logic       mon_en = 1'b1;
  int         rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  logic       gap_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: scan the stream into maximal equal-value chunks of at most
  // MAX_RUN; each chunk is a token or literals; last flag on the final symbol.
  task automatic push_expected(input logic [7:0] s[$]);
    logic [8:0] tmp[$];
    logic [8:0] e;
    logic [7:0] v;
    int i;
    int n;
    i = 0;
    while (i < s.size()) begin
      v = s[i];
      n = 0;
      while (i < s.size() && s[i] == v && n < MAX_RUN) begin
        n++;
        i++;
      end
      if (n >= MIN_RUN || v == ESC) begin
        tmp.push_back({1'b0, ESC});
        tmp.push_back({1'b0, 8'(n)});
        tmp.push_back({1'b0, v});
      end else begin
        repeat (n) tmp.push_back({1'b0, v});
      end
    end
    e = tmp.pop_back();
    e[8] = 1'b1;
    tmp.push_back(e);
    foreach (tmp[k]) exp_q.push_back(tmp[k]);
  endtask

  task automatic send_stream(input logic [7:0] s[$]);
    int t;
    push_expected(s);
    @(posedge fast_clk);
    #1;
    for (int i = 0; i < s.size(); i++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge fast_clk);
          #1;
        end
      end
      in_data  = s[i];
      in_last  = (i == s.size() - 1);
      in_valid = 1'b1;
      t = 0;
      @(negedge fast_clk);
      while (!in_ready && t < 5000) begin
        @(negedge fast_clk);
        t++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout actual=0 required=1");
      end
      @(posedge fast_clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge fast_clk);
    while ((exp_q.size() != 0 || out_valid) && t < 20000) begin
      @(negedge fast_clk);
      t++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", exp_q.size());
    end
  endtask

  // out_ready generator
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge fast_clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       prev_stall;
    logic [7:0] prev_dat;
    logic       prev_last;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_dat   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge fast_clk);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid) check("in_ready_during_emit", 32'(in_ready), 32'd0);
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(prev_dat));
          check("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[7:0]));
            check("out_last", 32'(out_last), 32'(e[8]));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_dat   = out_data;
        prev_last  = out_last;
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] s[$];
    logic [7:0] v;
    int nr;
    int len;
    reset    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(posedge fast_clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef RLE_STATS_EN
    check("rst_stat_in", stat_in_cnt, 32'd0);
    check("rst_stat_out", stat_out_cnt, 32'd0);
`endif
    reset = 1'b1;

    // 261 x AA then 55 (last): MAX_RUN split
    s.delete();
    repeat (261) s.push_back(8'hAA);
    s.push_back(8'h55);
    send_stream(s);
    drain();
`ifdef RLE_STATS_EN
    check("stat_in_cnt", stat_in_cnt, 32'd262);
    check("stat_out_cnt", stat_out_cnt, 32'd7);
`endif

    s = '{8'h01, 8'h01, 8'h03};
    send_stream(s);
    drain();
    s = '{8'h1B, 8'h04};
    send_stream(s);
    drain();

    // 5 x 07 with toggling out_ready
    rdy_mode = 1;
    s = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h07};
    send_stream(s);
    drain();

    // Randomized streams
    gap_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      rdy_mode = k % 3;
      s.delete();
      nr = $urandom_range(1, 8);
      for (int r = 0; r < nr; r++) begin
        case ($urandom_range(0, 3))
          0:       v = ESC;
          1:       v = 8'hAA;
          2:       v = 8'h07;
          default: v = 8'($urandom_range(0, 255));
        endcase
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 6);
        repeat (len) s.push_back(v);
      end
      send_stream(s);
    end
    drain();
    gap_en = 1'b0;

    // Reset while the count symbol of a 1B,04,07 token is on the output
    rdy_mode = 0;
    repeat (2) @(posedge fast_clk);
    mon_en = 1'b0;
    s = '{8'h07, 8'h07, 8'h07, 8'h07};
    send_stream(s);
    @(negedge fast_clk);
    check("mid_esc_sym", 32'(out_data), 32'h1B);
    @(negedge fast_clk);
    check("mid_cnt_sym", 32'(out_data), 32'h04);
    #1;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
`ifdef RLE_STATS_EN
    check("arst_stat_in", stat_in_cnt, 32'd0);
    check("arst_stat_out", stat_out_cnt, 32'd0);
`endif
    repeat (2) @(posedge fast_clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    s = '{8'h08};
    send_stream(s);
    drain();

    repeat (5) @(negedge fast_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
